axis_fifo_pkt: RTL and testbench

Parametrised synchronous AXI4-Stream FIFO with configurable data width and depth. It carries TLAST, reports its fill level and almost-full/almost-empty flags, and can optionally hold data back until a whole packet is stored. It sits between stream producers and consumers on a single clock domain, for example between the ingest DMA and the compute pipelines. It uses a strict valid/ready handshake on both sides: nothing is written while full and nothing is read while empty.

---
 rtl/axis_fifo_pkt.sv | 187 ++++++++++++++++++
 tb/tb_axis_fifo_pkt.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_fifo_pkt
//
// Synchronous AXI4-Stream FIFO with first-word-fall-through output. It stores
// data together with TLAST, and it reports the fill level and the
// almost-full/almost-empty flags as registered outputs.
//
// Optional build macro:
//   AXIS_FIFO_PACKET_MODE_EN - store-and-forward mode. The head is held back
//                              until a complete packet (a beat with last) has
//                              been stored. A full FIFO releases data in
//                              cut-through fashion, so packets longer than
//                              DEPTH cannot deadlock.
//
// Parameters:
//   DATA_WIDTH    - payload width in bits
//   DEPTH         - number of entries (power of two, >= 2)
//   AFULL_THRESH  - almost_full  when level >= AFULL_THRESH
//   AEMPTY_THRESH - almost_empty when level <= AEMPTY_THRESH
//
// Ports:
//   clk          - clock, all logic on the rising edge
//   reset        - synchronous active-high reset
//   in_valid     - producer has a beat
//   in_ready     - FIFO accepts a beat (registered, equals ~full)
//   in_data      - input payload
//   in_last      - input beat ends a packet
//   out_valid    - head beat available
//   out_ready    - consumer takes the head beat
//   out_data     - head payload
//   out_last     - head beat TLAST (0 while out_valid = 0)
//   level        - number of stored entries, 0..DEPTH
//   almost_full  - level >= AFULL_THRESH
//   almost_empty - level <= AEMPTY_THRESH
// -----------------------------------------------------------------------------
module axis_fifo_pkt #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);

  // Storage: {last, data} per entry. Contents are never cleared.
  logic [DATA_WIDTH:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] level_reg, level_next;
  logic          in_ready_reg;
  logic          almost_full_reg, almost_empty_reg;

  logic          empty, full, full_next;
  logic          wr_fire, rd_fire;
  logic [DATA_WIDTH:0] head;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // First-word-fall-through: the head entry drives the outputs directly.
  assign head = mem[rd_ptr_reg[AW-1:0]];

  assign wr_fire = in_valid & in_ready_reg;
  assign rd_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state pointers, level and flags
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_fire) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    // Modulo 2*DEPTH arithmetic falls out of the PW-bit width.
    level_next = wr_ptr_next - rd_ptr_next;
    full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                 (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      in_ready_reg     <= 1'b0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      level_reg        <= level_next;
      // Registered from the next-state pointers so it is exactly ~full
      // every cycle without a combinational path from out_ready.
      in_ready_reg     <= ~full_next;
      almost_full_reg  <= (level_next >= AFULL_L);
      almost_empty_reg <= (level_next <= AEMPTY_L);
    end
  end

  // Storage write port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= {in_last, in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Output qualification
  // ---------------------------------------------------------------------------
`ifdef AXIS_FIFO_PACKET_MODE_EN
  // Count of complete packets currently stored.
  logic [PW-1:0] pkt_cnt_reg, pkt_cnt_next;
  // Set once a beat of an incomplete packet has been released by the full
  // override; keeps the head flowing until that packet's last beat leaves.
  logic          cut_reg, cut_next;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr_fire & in_last;
  assign pkt_out = rd_fire & head[DATA_WIDTH];

  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (pkt_in && !pkt_out) begin
      pkt_cnt_next = pkt_cnt_reg + PTR_ONE;
    end else if (!pkt_in && pkt_out) begin
      pkt_cnt_next = pkt_cnt_reg - PTR_ONE;
    end

    cut_next = cut_reg;
    if (rd_fire) begin
      if (head[DATA_WIDTH]) begin
        cut_next = 1'b0;
      end else if (pkt_cnt_reg == '0) begin
        cut_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_reg <= '0;
      cut_reg     <= 1'b0;
    end else begin
      pkt_cnt_reg <= pkt_cnt_next;
      cut_reg     <= cut_next;
    end
  end

  assign out_valid = ~empty & ((pkt_cnt_reg != '0) | full | cut_reg);
`else
  assign out_valid = ~empty;
`endif

  assign out_data     = head[DATA_WIDTH-1:0];
  assign out_last     = out_valid & head[DATA_WIDTH];
  assign in_ready     = in_ready_reg;
  assign level        = level_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo_pkt
//
// Directed testbench for axis_fifo_pkt with default parameters (DEPTH = 16,
// DATA_WIDTH = 64, AFULL_THRESH = 14, AEMPTY_THRESH = 2). Covers reset, fill to
// full, read/write at full, wrap-around streaming and mid-operation reset.
// The packet-mode steps are built when AXIS_FIFO_PACKET_MODE_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_fifo_pkt;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic [4:0]  level;
  logic        almost_full;
  logic        almost_empty;

  int errors = 0;
  int checks = 0;

  axis_fifo_pkt dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    logic wr;
    logic rd;

    // ---------------- reset held 3 cycles with in_valid high ----------------
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_last   = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_aempty", 64'(almost_empty), 64'd1);
    end
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);

    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_level", 64'(level), 64'd0);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // ---------------- fill to full, no reads ----------------
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_last  = 1'b0;
      tick();
      chk("fill_level", 64'(level), 64'(i + 1));
      chk("fill_afull", 64'(almost_full), 64'(i + 1 >= 14));
      chk("fill_aempty", 64'(almost_empty), 64'(i + 1 <= 2));
      chk("fill_out_valid", 64'(out_valid), PKT ? 64'(i == 15) : 64'd1);
      chk("fill_head", out_data, 64'd0);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);

    // 17th beat is refused
    in_data = 64'h99;
    tick();
    chk("over_level", 64'(level), 64'd16);
    chk("over_in_ready", 64'(in_ready), 64'd0);
    chk("over_head", out_data, 64'd0);

    // ---------------- read at full, then write+read ----------------
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("atfull_level", 64'(level), 64'd15);
    chk("atfull_in_ready", 64'(in_ready), 64'd1);
    chk("atfull_head", out_data, 64'd1);

    in_valid = 1'b1;
    in_data  = 64'h10;
    in_last  = 1'b1;
    tick();
    chk("wr_rd_level", 64'(level), 64'd15);
    chk("wr_rd_head", out_data, 64'd2);
    chk("wr_rd_in_ready", 64'(in_ready), 64'd1);

    // drain: 2..15 then 0x10 (with last); 0x99 must never appear
    in_valid = 1'b0;
    for (int v = 2; v <= 16; v++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", out_data, 64'(v));
      chk("drain_last", 64'(out_last), 64'(v == 16));
      tick();
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_level", 64'(level), 64'd0);
    chk("drained_aempty", 64'(almost_empty), 64'd1);

    // ---------------- wrap-around streaming, 40 beats ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 64'h100 + 64'(i);
      tick();
      chk("wrap_level", 64'(level), 64'd1);
      chk("wrap_data", out_data, 64'h100 + 64'(i));
      chk("wrap_in_ready", 64'(in_ready), 64'd1);
      chk("wrap_last", 64'(out_last), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_end_level", 64'(level), 64'd0);
    chk("wrap_end_valid", 64'(out_valid), 64'd0);

    // ---------------- mid-operation reset ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data = 64'h30 + 64'(i);
      tick();
    end
    chk("mid_level7", 64'(level), 64'd7);

    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_aempty", 64'(almost_empty), 64'd1);

    reset = 1'b0;
    tick();
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rel_valid", 64'(out_valid), 64'd0);

    in_valid = 1'b1;
    in_data  = 64'hAA;
    in_last  = 1'b1;
    tick();
    chk("aa_valid", 64'(out_valid), 64'd1);
    chk("aa_data", out_data, 64'hAA);
    chk("aa_last", 64'(out_last), 64'd1);
    chk("aa_level", 64'(level), 64'd1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("aa_gone_valid", 64'(out_valid), 64'd0);
    chk("aa_gone_level", 64'(level), 64'd0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // ---------------- 4-beat packet held until complete ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h40 + 64'(i);
      in_last  = (i == 3);
      tick();
      chk("p4_hold_valid", 64'(out_valid), 64'(i == 3));
      chk("p4_level", 64'(level), 64'(i + 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("p4_out_valid", 64'(out_valid), 64'd1);
      chk("p4_out_data", out_data, 64'h40 + 64'(i));
      chk("p4_out_last", 64'(out_last), 64'(i == 3));
      tick();
    end
    chk("p4_done_valid", 64'(out_valid), 64'd0);

    // ---------------- 20-beat packet, longer than DEPTH ----------------
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      in_valid = (sent < 20);
      in_data  = 64'h200 + 64'(sent);
      in_last  = (sent == 19);
      wr = in_valid & in_ready;
      rd = out_valid & out_ready;
      if (sent < 16) begin
        chk("p20_hold_valid", 64'(out_valid), 64'd0);
      end
      if (rd) begin
        if (got == 0) begin
          chk("p20_start_at_full", 64'(sent), 64'd16);
        end
        chk("p20_data", out_data, 64'h200 + 64'(got));
        chk("p20_last", 64'(out_last), 64'(got == 19));
      end
      tick();
      if (wr) sent++;
      if (rd) got++;
    end
    in_valid = 1'b0;
    chk("p20_count", 64'(got), 64'd20);
    chk("p20_end_level", 64'(level), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
